ipg_egress_arbiter: RTL and testbench
=====================================

Name: ipg_egress_arbiter

Overview:
- Shares one egress IPG transmit slot between NUM_PORTS ingress request streams inside the switch.
- Each input stream is an upstream-buffered, valid/ready frame stream. Word 0 of each frame is a header carrying src, dst and request type.
- The block selects frames whose dst equals EGRESS_ID, grants the slot per frame with round-robin fairness, and forwards the whole frame to the egress encoder.
- Stalled frames are aborted by a watchdog; grant, abort and drop statistics are kept.

Parameters:
- NUM_PORTS, 4, number of ingress requesters (2..8).
- DATA_WIDTH, 64, stream word width.
- ADR_WIDTH, 40, combined src+dst width; each field is ADR_WIDTH/2 bits.
- EGRESS_ID, 0, dst value (ADR_WIDTH/2 bits) served by this egress.
- TIMEOUT, 64, maximum idle cycles inside a granted frame before abort (≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_data  in  NUM_PORTS*DATA_WIDTH  input words; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  NUM_PORTS  per-port word valid.
- s_last  in  NUM_PORTS  per-port last word of frame.
- s_ready  out  NUM_PORTS  per-port accept.
- m_data  out  DATA_WIDTH  forwarded word.
- m_valid  out  1  forwarded word valid.
- m_last  out  1  forwarded last word.
- m_abort  out  1  one-cycle pulse: current egress frame truncated.
- m_ready  in  1  egress slot accepts a word.
- grant  out  NUM_PORTS  one-hot owner of the slot; 0 when idle.
- grant_count  out  16  granted frames, wraps.
- abort_count  out  8  watchdog aborts, saturates at 255.
- drop_count  out  8  non-header head words flushed, saturates at 255.

Behaviour:
- Reset, asynchronous on rst:
  - state IDLE; grant=0; round-robin pointer rr=0.
  - All counters 0; m_abort=0.
  - Outputs m_valid=0, m_last=0, m_data=0 and s_ready=0.
- Header word decode: data[7:4]==4'h2. Fields:
  - type = data[3:0]; 0 = wreq, 1 = rreq, 2 = rresp.
  - src = data[DATA_WIDTH-17 -: ADR_WIDTH/2].
  - dst = the next ADR_WIDTH/2 bits below src.
- Port i requests when s_valid[i] is high, its head word is a header, and dst == EGRESS_ID.
- IDLE:
  - Ports whose valid head word is not a header get s_ready[i]=1 for that cycle. The word is discarded and drop_count increments once per flushed word; simultaneous flushes count as one each, saturating.
  - Header words with dst != EGRESS_ID are left untouched: s_ready=0, not dropped.
  - If any port requests, pick the first requester at or after rr (wrapping). Register it into grant, increment grant_count, go to XFER. Granting takes 1 cycle; no words are forwarded in IDLE.
- XFER, owner g:
  - Combinational passthrough: m_data=s_data[g], m_valid=s_valid[g], m_last=s_last[g], s_ready[g]=m_ready. All other s_ready bits are 0.
  - On s_valid[g] & m_ready & s_last[g]: rr=g+1 mod NUM_PORTS, grant=0, go to IDLE. The next grant appears no earlier than the following cycle, giving a 1-cycle bubble between frames.
  - Watchdog:
    - Counts consecutive cycles with s_valid[g]=0; it resets on any valid word.
    - m_ready low does not count, since backpressure is not a stall.
    - When the count reaches TIMEOUT: assert m_abort for one cycle, increment abort_count, set rr=g+1, clear grant, go to DRAIN.
- DRAIN:
  - Holds s_ready[g]=1 and discards words until s_valid[g]&s_last[g], then goes to IDLE.
  - m_valid stays 0 while in DRAIN.
- Frame length is unbounded. Single-word frames (header with s_last) are legal and complete in the grant cycle+1.
- Owner deasserting s_valid mid-frame and resuming before TIMEOUT: no effect beyond gaps in m_valid.
- rst asserted mid-frame: immediate return to reset values; the partial egress frame is not flagged with m_abort.
- At most one grant bit is ever set; grant is never granted to a port whose head is not a matching header.

Optional Feature:
- Macro: IPG_EGRESS_RRESP_PRIO_EN.
- Defined: in IDLE, requesters whose header type==2 (rresp) form a high-priority class, arbitrated round-robin among themselves from rr. Other requesters are granted only when no rresp requester exists. rr updates identically to the base behaviour.
- Undefined: type is ignored and pure round-robin applies.

Test Plan:
- Port 1 sends a 3-word frame with header 0x0000_0000_0000_0020 (dst=0, type 0), m_ready=1 -> grant=4'b0010 one cycle after valid; 3 words on m_data in order; m_last on word 3; grant_count=1; rr=2.
- Ports 0, 2 and 3 each present a 2-word frame simultaneously with rr=0 -> granted in order 0, 2, 3, with a 1-cycle bubble between frames; grant_count=3.
- Port 2 head word 0x...0010 (not a header) -> s_ready[2] pulses; drop_count=1; no grant. Header with dst=5 -> no grant; s_ready[2] stays 0.
- Owner port 0 stalls s_valid after word 1 for 64 cycles with TIMEOUT=64 -> m_abort pulses once; abort_count=1; remaining words drained until s_last; m_valid stays 0 during drain.
- m_ready held low for 200 cycles mid-frame -> no abort; frame completes intact after m_ready returns.
- With IPG_EGRESS_RRESP_PRIO_EN defined, rr=0, port 0 presents wreq and port 3 presents rresp -> port 3 is granted first; without the macro, port 0 is granted first.

Source files
------------

// File: rtl/ipg_egress_arbiter.sv
// ---------------------------------------------------------------------------
// ipg_egress_arbiter
//
// Purpose:
//   Shares one egress IPG transmit slot between NUM_PORTS ingress valid/ready
//   frame streams. The first word of each frame is a header (data[7:4]==4'h2)
//   that carries type, src and dst. The arbiter works as follows:
//     - Frames whose dst equals EGRESS_ID are granted one whole frame at a
//       time, with round-robin fairness, and passed through to the egress.
//     - Non-header head words seen while idle are flushed and counted.
//     - A watchdog aborts a granted frame that stalls for TIMEOUT cycles.
//
// Optional feature (macro IPG_EGRESS_RRESP_PRIO_EN):
//   When defined, requesters whose header type is 2 (rresp) are served
//   before every other requester. Round-robin still applies inside each
//   class. When undefined, the header type is ignored.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_data/s_valid/     per-port input streams (port i owns
//   s_last/s_ready        s_data[i*DATA_WIDTH +: DATA_WIDTH])
//   m_data/m_valid/     forwarded egress stream
//   m_last/m_ready
//   m_abort             one-cycle pulse: current egress frame truncated
//   grant               one-hot slot owner, 0 when idle
//   grant_count         granted frames (wraps)
//   abort_count         watchdog aborts (saturates)
//   drop_count          flushed non-header head words (saturates)
// ---------------------------------------------------------------------------
module ipg_egress_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADR_WIDTH  = 40,
  parameter int EGRESS_ID  = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  output logic                            m_last,
  output logic                            m_abort,
  input  logic                            m_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [15:0]                     grant_count,
  output logic [7:0]                      abort_count,
  output logic [7:0]                      drop_count
);

  localparam int HALF    = ADR_WIDTH / 2;
  // src sits at [DATA_WIDTH-17 -: HALF]; dst occupies the HALF bits below it.
  localparam int DST_MSB = DATA_WIDTH - 17 - HALF;
  localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int WW      = $clog2(TIMEOUT + 1);
  localparam logic [HALF-1:0] EGRESS_DST = HALF'(EGRESS_ID);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [PW-1:0]          rr_q, rr_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic [15:0]            grant_count_q, grant_count_d;
  logic [7:0]             abort_count_q, abort_count_d;
  logic [7:0]             drop_count_q, drop_count_d;
  logic                   m_abort_q, m_abort_d;

  // -------------------------------------------------------------------------
  // Head-word decode
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  word [NUM_PORTS];
  logic [NUM_PORTS-1:0]   is_hdr;
  logic [NUM_PORTS-1:0]   is_req;
`ifdef IPG_EGRESS_RRESP_PRIO_EN
  logic [NUM_PORTS-1:0]   is_rresp;
`endif

  // NOTE: every combinational output gets a default before any branch; a
  // path that leaves a variable unassigned would infer a latch.
  always_comb begin
    is_hdr = '0;
    is_req = '0;
`ifdef IPG_EGRESS_RRESP_PRIO_EN
    is_rresp = '0;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      word[i]   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      is_hdr[i] = (word[i][7:4] == 4'h2);
      is_req[i] = s_valid[i] && is_hdr[i] &&
                  (word[i][DST_MSB -: HALF] == EGRESS_DST);
`ifdef IPG_EGRESS_RRESP_PRIO_EN
      is_rresp[i] = (word[i][3:0] == 4'h2);
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pick: first candidate at or after rr, wrapping
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] cand;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;

  function automatic int wrap_idx(input int a);
    return a % NUM_PORTS;
  endfunction

  always_comb begin
`ifdef IPG_EGRESS_RRESP_PRIO_EN
    cand = (|(is_req & is_rresp)) ? (is_req & is_rresp) : is_req;
`else
    cand = is_req;
`endif
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!pick_valid && cand[wrap_idx(int'(rr_q) + k)]) begin
        pick_valid = 1'b1;
        pick_idx   = PW'(wrap_idx(int'(rr_q) + k));
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and outputs
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] flush;
  logic [PW-1:0]        rr_next;
  int                   drop_sum;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    wd_d          = wd_q;
    grant_count_d = grant_count_q;
    abort_count_d = abort_count_q;
    drop_count_d  = drop_count_q;
    m_abort_d     = 1'b0;
    s_ready       = '0;
    m_data        = '0;
    m_valid       = 1'b0;
    m_last        = 1'b0;
    flush         = '0;
    drop_sum      = int'(drop_count_q);
    rr_next       = (int'(owner_q) == NUM_PORTS - 1) ? '0 : owner_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        // Flushing is suppressed while reset is held so s_ready stays low.
        flush   = s_valid & ~is_hdr & {NUM_PORTS{~rst}};
        s_ready = flush;
        for (int i = 0; i < NUM_PORTS; i++) begin
          drop_sum = drop_sum + int'(flush[i]);
        end
        drop_count_d = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
        if (pick_valid) begin
          owner_d            = pick_idx;
          grant_d            = '0;
          grant_d[pick_idx]  = 1'b1;
          wd_d               = '0;
          grant_count_d      = grant_count_q + 16'd1;
          state_d            = ST_XFER;
        end
      end

      ST_XFER: begin
        m_data           = word[owner_q];
        m_valid          = s_valid[owner_q];
        m_last           = s_last[owner_q];
        s_ready[owner_q] = m_ready;
        if (s_valid[owner_q]) begin
          // Only an absent word counts as a stall; backpressure never does.
          wd_d = '0;
          if (m_ready && s_last[owner_q]) begin
            rr_d    = rr_next;
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          m_abort_d     = 1'b1;
          abort_count_d = (abort_count_q == 8'hFF) ? 8'hFF : abort_count_q + 8'd1;
          rr_d          = rr_next;
          grant_d       = '0;
          wd_d          = '0;
          state_d       = ST_DRAIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        // Swallow the rest of the aborted frame; nothing reaches the egress.
        s_ready[owner_q] = 1'b1;
        if (s_valid[owner_q] && s_last[owner_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      rr_q          <= '0;
      grant_q       <= '0;
      wd_q          <= '0;
      grant_count_q <= '0;
      abort_count_q <= '0;
      drop_count_q  <= '0;
      m_abort_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      grant_q       <= grant_d;
      wd_q          <= wd_d;
      grant_count_q <= grant_count_d;
      abort_count_q <= abort_count_d;
      drop_count_q  <= drop_count_d;
      m_abort_q     <= m_abort_d;
    end
  end

  assign grant       = grant_q;
  assign m_abort     = m_abort_q;
  assign grant_count = grant_count_q;
  assign abort_count = abort_count_q;
  assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_ipg_egress_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ipg_egress_arbiter
//
// Self-checking bench for ipg_egress_arbiter at default parameters
// (4 ports, 64-bit data, 40-bit address, EGRESS_ID 0, TIMEOUT 64).
// A table of single-word head vectors checks the header decode, flushing and
// grant. Hand-written sequences then cover the multi-cycle behaviour:
//   - multi-word frames
//   - round-robin order and the bubble between frames
//   - watchdog abort and drain
//   - backpressure
//   - rresp priority
//   - drop saturation
//   - reset mid-frame
// ---------------------------------------------------------------------------
module tb_ipg_egress_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*DW-1:0]  s_data;
  logic [NP-1:0]     s_valid;
  logic [NP-1:0]     s_last;
  logic [NP-1:0]     s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_abort;
  logic              m_ready;
  logic [NP-1:0]     grant;
  logic [15:0]       grant_count;
  logic [7:0]        abort_count;
  logic [7:0]        drop_count;

  ipg_egress_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_abort     (m_abort),
    .m_ready     (m_ready),
    .grant       (grant),
    .grant_count (grant_count),
    .abort_count (abort_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Bookkeeping
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-port word queues, single-shot forced words and flood flags
  logic [63:0] mem   [NP][16];
  logic        ml    [NP][16];
  int          hd    [NP];
  int          tl    [NP];
  bit          fv    [NP];
  logic [63:0] fd    [NP];
  bit          stall [NP];
  bit          flood [NP];
  logic [63:0] hdr_of[NP];

  // Monitor state
  logic [63:0] beat_d [64];
  logic        beat_l [64];
  int          nb;
  logic [3:0]  gseq [8];
  int          ng;
  logic [3:0]  g_now, g_prev, sr_now;
  int          n_abort_pulse, n_bad_valid, n_nobubble;
  bit          acc [NP];

  int          model_grant, model_drop;

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      if (flood[p]) begin
        s_valid[p] = 1'b1; s_last[p] = 1'b0; s_data[p*DW +: DW] = 64'h10;
      end else if (fv[p]) begin
        s_valid[p] = 1'b1; s_last[p] = 1'b1; s_data[p*DW +: DW] = fd[p];
      end else if (hd[p] < tl[p] && !stall[p]) begin
        s_valid[p] = 1'b1; s_last[p] = ml[p][hd[p]]; s_data[p*DW +: DW] = mem[p][hd[p]];
      end else begin
        s_valid[p] = 1'b0; s_last[p] = 1'b0; s_data[p*DW +: DW] = '0;
      end
    end
  endtask

  task automatic add_word(input int p, input logic [63:0] d, input logic l);
    if (hd[p] == tl[p]) begin hd[p] = 0; tl[p] = 0; end
    mem[p][tl[p]] = d;
    ml[p][tl[p]]  = l;
    tl[p]++;
  endtask

  task automatic load_frame2(input int p, input logic [63:0] hdr);
    add_word(p, hdr, 1'b0);
    add_word(p, 64'hB0 | 64'(p), 1'b1);
    hdr_of[p] = hdr;
  endtask

  // One clock: sample at the falling edge, update drivers just after the rise.
  task automatic tick();
    @(negedge clk);
    g_now  = grant;
    sr_now = s_ready;
    for (int p = 0; p < NP; p++) acc[p] = s_valid[p] && s_ready[p];
    if (m_valid && m_ready && nb < 64) begin
      beat_d[nb] = m_data; beat_l[nb] = m_last; nb++;
    end
    if (m_abort) n_abort_pulse++;
    if (m_valid && grant == '0) n_bad_valid++;
    if (grant != '0 && grant != g_prev) begin
      if (g_prev != '0) n_nobubble++;
      if (ng < 8) begin gseq[ng] = grant; ng++; end
    end
    g_prev = grant;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p]) begin
        if (fv[p]) fv[p] = 1'b0;
        else if (hd[p] < tl[p]) hd[p]++;
      end
    end
    refresh();
  endtask

  function automatic bit busy();
    for (int p = 0; p < NP; p++) if (hd[p] < tl[p] || fv[p]) return 1'b1;
    return g_now != '0;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (busy() && k < budget) begin tick(); k++; end
    check({name, "_done"}, 64'(k < budget), 64'd1);
  endtask

  task automatic wait_hd(input string name, input int p, input int n, input int budget);
    int k = 0;
    while (hd[p] < n && k < budget) begin tick(); k++; end
    check({name, "_progress"}, 64'(hd[p] >= n), 64'd1);
  endtask

  // Checks grant order and forwarded words of two-word frames from load_frame2.
  task automatic run_order(input string name, input int n, input int ord[4]);
    int b;
    nb = 0; ng = 0; b = n_nobubble;
    wait_done(name, 80);
    check({name, "_ngrants"}, 64'(ng), 64'(n));
    for (int i = 0; i < n; i++) begin
      check({name, "_grant"}, 64'(gseq[i]), 64'(4'b1 << ord[i]));
      check({name, "_hdr"},   beat_d[2*i],   hdr_of[ord[i]]);
      check({name, "_word1"}, beat_d[2*i+1], 64'hB0 | 64'(ord[i]));
      check({name, "_last1"}, 64'(beat_l[2*i+1]), 64'd1);
    end
    check({name, "_bubble"}, 64'(n_nobubble - b), 64'd0);
    model_grant += n;
    check({name, "_grant_count"}, 64'(grant_count), 64'(model_grant));
  endtask

  // -------------------------------------------------------------------------
  // Head-word vector table
  // -------------------------------------------------------------------------
  typedef struct {
    int          port;
    logic [63:0] word;
    logic [3:0]  exp_sready;  // s_ready in the idle cycle the word is shown
    logic [3:0]  exp_grant;   // grant one cycle later
  } vec_t;

  vec_t vecs [9];

  initial begin
    int ord[4];
    int base, abort_at;

    vecs[0] = '{2, 64'h10,                  4'b0100, 4'b0000}; // not a header
    vecs[1] = '{2, 64'h520,                 4'b0000, 4'b0000}; // dst=5
    vecs[2] = '{1, 64'h20,                  4'b0000, 4'b0010}; // wreq dst=0
    vecs[3] = '{3, 64'h21,                  4'b0000, 4'b1000}; // rreq dst=0
    vecs[4] = '{0, 64'h0F,                  4'b0001, 4'b0000}; // not a header
    vecs[5] = '{0, 64'h0000_ABCD_E000_0022, 4'b0000, 4'b0001}; // src set, dst=0
    vecs[6] = '{1, 64'h120,                 4'b0000, 4'b0000}; // dst=1
    vecs[7] = '{2, 64'hFFFF_0000_0000_0020, 4'b0000, 4'b0100}; // bits above src
    vecs[8] = '{3, 64'h30,                  4'b1000, 4'b0000}; // not a header

    for (int p = 0; p < NP; p++) begin
      hd[p] = 0; tl[p] = 0; fv[p] = 0; fd[p] = '0; stall[p] = 0; flood[p] = 0; hdr_of[p] = '0;
    end
    nb = 0; ng = 0; g_now = '0; g_prev = '0; sr_now = '0;
    n_abort_pulse = 0; n_bad_valid = 0; n_nobubble = 0;
    model_grant = 0; model_drop = 0;
    s_data = '0; s_valid = '0; s_last = '0; m_ready = 1'b1;

    // ---- Reset values ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant",       64'(grant),       64'd0);
    check("rst_m_valid",     64'(m_valid),     64'd0);
    check("rst_m_last",      64'(m_last),      64'd0);
    check("rst_m_data",      m_data,           64'd0);
    check("rst_s_ready",     64'(s_ready),     64'd0);
    check("rst_m_abort",     64'(m_abort),     64'd0);
    check("rst_grant_count", 64'(grant_count), 64'd0);
    check("rst_abort_count", 64'(abort_count), 64'd0);
    check("rst_drop_count",  64'(drop_count),  64'd0);
    rst = 1'b0;
    refresh();

    // ---- Table: one head word from idle ----
    for (int v = 0; v < 9; v++) begin
      fv[vecs[v].port] = 1'b1;
      fd[vecs[v].port] = vecs[v].word;
      refresh();
      nb = 0;
      tick();
      check("vec_s_ready",    64'(sr_now), 64'(vecs[v].exp_sready));
      check("vec_idle_grant", 64'(g_now),  64'd0);
      if (vecs[v].exp_sready == '0 && vecs[v].exp_grant == '0) begin
        fv[vecs[v].port] = 1'b0;
        refresh();
      end
      tick();
      check("vec_grant", 64'(g_now), 64'(vecs[v].exp_grant));
      check("vec_beats", 64'(nb), (vecs[v].exp_grant != '0) ? 64'd1 : 64'd0);
      if (vecs[v].exp_grant != '0 && nb > 0) begin
        check("vec_m_data", beat_d[0], vecs[v].word);
        check("vec_m_last", 64'(beat_l[0]), 64'd1);
      end
      tick();
      check("vec_release", 64'(g_now), 64'd0);
      if (vecs[v].exp_sready != '0) model_drop++;
      if (vecs[v].exp_grant  != '0) model_grant++;
      check("vec_drop_count",  64'(drop_count),  64'(model_drop));
      check("vec_grant_count", 64'(grant_count), 64'(model_grant));
    end

    // ---- A: port 1 three-word frame (rr=3 here) ----
    nb = 0;
    add_word(1, 64'h20, 1'b0);
    add_word(1, 64'hA1, 1'b0);
    add_word(1, 64'hA2, 1'b1);
    refresh();
    tick();
    check("A_grant_latency", 64'(g_now), 64'd0);
    tick();
    check("A_grant", 64'(g_now), 64'b0010);
    wait_done("A", 20);
    check("A_nbeats", 64'(nb), 64'd3);
    check("A_w0", beat_d[0], 64'h20);
    check("A_w1", beat_d[1], 64'hA1);
    check("A_w2", beat_d[2], 64'hA2);
    check("A_lasts", {61'd0, beat_l[0], beat_l[1], beat_l[2]}, 64'b001);
    model_grant++;
    check("A_grant_count", 64'(grant_count), 64'(model_grant));

    // ---- B1: ports 0,2,3 together with rr=2 -> 2,3,0 ----
    load_frame2(0, 64'h20); load_frame2(2, 64'h20); load_frame2(3, 64'h20);
    refresh();
    ord = '{2, 3, 0, 0};
    run_order("B1", 3, ord);

    // Port 3 alone brings rr back to 0.
    load_frame2(3, 64'h20);
    refresh();
    ord = '{3, 0, 0, 0};
    run_order("B0", 1, ord);

    // ---- B2: ports 0,2,3 together with rr=0 -> 0,2,3 ----
    load_frame2(0, 64'h20); load_frame2(2, 64'h20); load_frame2(3, 64'h20);
    refresh();
    ord = '{0, 2, 3, 0};
    run_order("B2", 3, ord);

    // ---- C: watchdog abort on port 0 after one word ----
    nb = 0;
    add_word(0, 64'h20, 1'b0);
    add_word(0, 64'hC1, 1'b0);
    add_word(0, 64'hC2, 1'b0);
    add_word(0, 64'hC3, 1'b1);
    refresh();
    wait_hd("C", 0, 1, 10);
    stall[0] = 1'b1;
    refresh();
    base = n_abort_pulse;
    abort_at = -1;
    for (int s = 1; s <= 70; s++) begin
      tick();
      if (abort_at < 0 && n_abort_pulse != base) abort_at = s;
    end
    check("C_abort_timing", 64'(abort_at >= 64 && abort_at <= 65), 64'd1);
    check("C_abort_pulses", 64'(n_abort_pulse - base), 64'd1);
    check("C_grant_cleared", 64'(g_now), 64'd0);
    check("C_abort_count", 64'(abort_count), 64'd1);
    stall[0] = 1'b0;
    refresh();
    wait_done("C_drain", 20);
    check("C_only_header", 64'(nb), 64'd1);
    check("C_no_valid_in_drain", 64'(n_bad_valid), 64'd0);
    model_grant++;
    check("C_grant_count", 64'(grant_count), 64'(model_grant));

    // ---- D: backpressure for 200 cycles, then a short valid gap (rr=1) ----
    nb = 0;
    base = n_abort_pulse;
    add_word(1, 64'h20, 1'b0);
    add_word(1, 64'hD1, 1'b0);
    add_word(1, 64'hD2, 1'b0);
    add_word(1, 64'hD3, 1'b1);
    refresh();
    wait_hd("D", 1, 1, 10);
    m_ready = 1'b0;
    repeat (200) tick();
    check("D_held", 64'(hd[1]), 64'd1);
    check("D_grant_held", 64'(g_now), 64'b0010);
    m_ready = 1'b1;
    wait_hd("D2", 1, 2, 10);
    stall[1] = 1'b1;
    refresh();
    repeat (40) tick();
    stall[1] = 1'b0;
    refresh();
    wait_done("D", 20);
    check("D_no_abort", 64'(n_abort_pulse - base), 64'd0);
    check("D_abort_count", 64'(abort_count), 64'd1);
    check("D_nbeats", 64'(nb), 64'd4);
    check("D_w1", beat_d[1], 64'hD1);
    check("D_w3", beat_d[3], 64'hD3);
    check("D_lasts", {60'd0, beat_l[0], beat_l[1], beat_l[2], beat_l[3]}, 64'b0001);
    model_grant++;

    // ---- E: rresp priority (rr brought to 0 via port 3) ----
    load_frame2(3, 64'h20);
    refresh();
    ord = '{3, 0, 0, 0};
    run_order("E0", 1, ord);
    load_frame2(0, 64'h20);
    load_frame2(3, 64'h22);
    refresh();
`ifdef IPG_EGRESS_RRESP_PRIO_EN
    ord = '{3, 0, 0, 0};
`else
    ord = '{0, 3, 0, 0};
`endif
    run_order("E", 2, ord);

    // ---- F: simultaneous flushes, then drop saturation ----
    for (int p = 0; p < NP; p++) begin fv[p] = 1'b1; fd[p] = 64'h10; end
    refresh();
    tick();
    check("F_s_ready_all", 64'(sr_now), 64'hF);
    model_drop += 4;
    tick();
    check("F_drop4", 64'(drop_count), 64'(model_drop));
    flood[2] = 1'b1;
    refresh();
    repeat (260) tick();
    flood[2] = 1'b0;
    refresh();
    tick();
    check("F_drop_sat", 64'(drop_count), 64'd255);
    check("F_no_grant", 64'(g_now), 64'd0);

    // ---- G: reset mid-frame ----
    base = n_abort_pulse;
    add_word(1, 64'h20, 1'b0);
    add_word(1, 64'hE1, 1'b0);
    add_word(1, 64'hE2, 1'b1);
    refresh();
    wait_hd("G", 1, 1, 10);
    rst = 1'b1;
    #1;
    check("G_grant",       64'(grant),       64'd0);
    check("G_m_valid",     64'(m_valid),     64'd0);
    check("G_s_ready",     64'(s_ready),     64'd0);
    check("G_grant_count", 64'(grant_count), 64'd0);
    check("G_drop_count",  64'(drop_count),  64'd0);
    check("G_abort_count", 64'(abort_count), 64'd0);
    for (int p = 0; p < NP; p++) begin hd[p] = 0; tl[p] = 0; end
    refresh();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) tick();
    check("G_no_abort", 64'(n_abort_pulse - base), 64'd0);
    check("G_idle", 64'(g_now), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
